immgen_stage: RTL
=================

Name: immgen_stage

Overview:
- Registered, handshaked immediate-generation stage between fetch and execute.
- Decodes every RV32I immediate format (I, S, B, U, J) and sign-extends to XLEN.
- Computes the PC-relative target for B, J and AUIPC.
- Reports format and recognition status.
- Has a 2-entry skid buffer, so upstream ready is a registered signal and back-pressure loses no instruction.

Parameters:
- XLEN, 32, datapath width of imm/pc/target; legal values 32 or 64; all immediates sign-extended from their top bit to XLEN.
- SUPPORT_UJ, 1, when 0 the U and J opcodes are treated as unrecognised (imm 0, fmt NONE, imm_valid 0).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  instruction/pc valid this cycle
- in_ready  output  1  stage can accept; registered, equals !skid_full
- instruction  input  32  raw instruction word
- pc  input  XLEN  address of instruction
- out_valid  output  1  output payload valid
- out_ready  input  1  downstream accepts payload
- imm  output  XLEN  sign-extended immediate
- target  output  XLEN  pc+imm for B/J/AUIPC, else 0
- fmt  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
- imm_valid  output  1  opcode recognised

Behaviour:
- Reset (async assert, sync deassert handled upstream): out_valid=0, in_ready=1, skid empty, imm=0, target=0, fmt=0, imm_valid=0. Reset mid-transfer discards both entries; no output is produced from pre-reset inputs.
- Transfer rules: input accepted when in_valid&&in_ready; output consumed when out_valid&&out_ready. Payload must be held stable while out_valid&&!out_ready.
- Latency: accepted word appears on outputs next cycle if the output register is empty or is being consumed that cycle.
- Decode by instruction[6:0]:
  - 0000011 load, 0010011 OP-IMM, 1100111 JALR: I, imm = sext(inst[31:20]).
  - OP-IMM shifts (funct3 001 or 101): imm = zero-extended inst[24:20], fmt I. For XLEN=64 use inst[25:20].
  - 0100011: S, sext({inst[31:25],inst[11:7]}).
  - 1100011: B, sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - 0110111 LUI and 0010111 AUIPC: U, sext({inst[31:12],12'b0}).
  - 1101111: J, sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - Any other opcode: NONE, imm=0, imm_valid=0.
- target = pc+imm modulo 2^XLEN (wrap, no flag) for B, J, AUIPC. target = 0 for all other formats, including JALR.
- Skid buffer states:
  - EMPTY: out_valid=0.
  - ONE: output register full, skid empty.
  - FULL: both full, in_ready=0.
- Transitions:
  - EMPTY→ONE on accept.
  - ONE→ONE on accept+consume.
  - ONE→FULL on accept without consume.
  - ONE→EMPTY on consume without accept.
  - FULL→ONE on consume; skid moves to output register, and in_ready rises the following cycle.
- No accept is possible in FULL.
- Order is strictly FIFO; no duplication or drop.
- Decode is combinational on input; decoded payload, not raw instruction, is stored in both registers.

Test Plan:
- Reset, then in_valid with instruction 0xFFC4A303 (lw x6,-4(x9)), pc 0x100, out_ready=1 → next cycle out_valid=1, imm=0xFFFFFFFC, fmt=1, imm_valid=1, target=0.
- Branch 0xFE000EE3 (beq x0,x0,-4), pc 0x0000_0010 → imm=0xFFFFFFFC, fmt=3, target=0x0000000C. pc=0x0, same word → target=0xFFFFFFFC (wrap).
- JAL 0x0080006F, AUIPC 0x12345097, SW 0x00112623, SLLI 0x01F09093 → imm 0x8, 0x12345000, 0xC, 0x1F; fmt 5, 4, 2, 1.
- out_ready=0 with 3 back-to-back valids → first two accepted, in_ready=0 from cycle after second. Raise out_ready → order 1,2,3 preserved; outputs stable while stalled.
- Opcode 0110011 (R-type) → fmt=0, imm=0, imm_valid=0, out_valid still 1. SUPPORT_UJ=0 with JAL → same NONE result.
- Assert rst while FULL → out_valid=0 and in_ready=1 immediately (async). No stale output after release.

Source files
------------

// File: rtl/immgen_stage.sv
// RV32I immediate/target decode stage with a two-entry skid buffer.
// Decoded payload is registered; upstream ready comes straight from a flop.
module immgen_stage #(
    parameter int XLEN       = 32,
    parameter bit SUPPORT_UJ = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] target,
    output logic [2:0]      fmt,
    output logic            imm_valid
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [2:0]      fmt;
        logic            imm_valid;
    } pay_t;

    typedef enum logic [2:0] {
        F_NONE = 3'd0,
        F_I    = 3'd1,
        F_S    = 3'd2,
        F_B    = 3'd3,
        F_U    = 3'd4,
        F_J    = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_opimm;
    logic            is_shift;
    logic            is_itype;
    logic            uj_ok;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_sh;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    pay_t            dec;

    assign opcode   = instruction[6:0];
    assign funct3   = instruction[14:12];
    assign uj_ok    = SUPPORT_UJ;
    assign is_opimm = (opcode == OP_IMM);
    assign is_shift = is_opimm && (funct3[1:0] == 2'b01);
    assign is_itype = (opcode == OP_LOAD) || (opcode == OP_JALR) ||
                      (is_opimm && !is_shift);

    assign imm_i = XLEN'($signed(instruction[31:20]));
    assign imm_s = XLEN'($signed({instruction[31:25], instruction[11:7]}));
    assign imm_b = XLEN'($signed({instruction[31], instruction[7],
                                  instruction[30:25], instruction[11:8],
                                  1'b0}));
    assign imm_u = XLEN'($signed({instruction[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({instruction[31], instruction[19:12],
                                  instruction[20], instruction[30:21],
                                  1'b0}));

    // Shift amount widens by one bit on RV64.
    assign imm_sh = (XLEN == 64) ? XLEN'(instruction[25:20])
                                 : XLEN'(instruction[24:20]);

    always_comb begin
        dec = '0;
        unique case (1'b1)
            is_itype: begin
                dec.imm       = imm_i;
                dec.fmt       = F_I;
                dec.imm_valid = 1'b1;
            end
            is_shift: begin
                dec.imm       = imm_sh;
                dec.fmt       = F_I;
                dec.imm_valid = 1'b1;
            end
            (opcode == OP_STORE): begin
                dec.imm       = imm_s;
                dec.fmt       = F_S;
                dec.imm_valid = 1'b1;
            end
            (opcode == OP_BRANCH): begin
                dec.imm       = imm_b;
                dec.fmt       = F_B;
                dec.imm_valid = 1'b1;
            end
            (uj_ok && ((opcode == OP_LUI) || (opcode == OP_AUIPC))): begin
                dec.imm       = imm_u;
                dec.fmt       = F_U;
                dec.imm_valid = 1'b1;
            end
            (uj_ok && (opcode == OP_JAL)): begin
                dec.imm       = imm_j;
                dec.fmt       = F_J;
                dec.imm_valid = 1'b1;
            end
            default: begin
                dec = '0;
            end
        endcase
        // JALR is register-relative, so it gets no target.
        if ((dec.fmt == F_B) || (dec.fmt == F_J) ||
            ((dec.fmt == F_U) && (opcode == OP_AUIPC))) begin
            dec.target = pc + dec.imm;
        end
    end

    state_e state;
    state_e state_n;
    pay_t   out_q;
    pay_t   skid_q;
    pay_t   out_d;
    logic   in_ready_q;
    logic   load_out;
    logic   load_skid;
    logic   accept;
    logic   consume;

    assign out_valid = (state != EMPTY);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid && in_ready_q;
    assign consume   = out_valid && out_ready;

    always_comb begin
        state_n   = state;
        load_out  = 1'b0;
        load_skid = 1'b0;
        out_d     = dec;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    load_out = 1'b1;
                    state_n  = ONE;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_n   = FULL;
                end else if (consume) begin
                    state_n = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    out_d    = skid_q;
                    load_out = 1'b1;
                    state_n  = ONE;
                end
            end
            default: begin
                state_n = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            state      <= state_n;
            in_ready_q <= (state_n != FULL);
            if (load_out) begin
                out_q <= out_d;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
        end
    end

    assign imm       = out_q.imm;
    assign target    = out_q.target;
    assign fmt       = out_q.fmt;
    assign imm_valid = out_q.imm_valid;

endmodule
